avr_prefetch_unit: RTL
======================

Name: avr_prefetch_unit

Overview:
Parametrised successor to the single-register fetch stage. It decouples program-memory fetch from decode with a DEPTH-entry prefetch queue and tracks the PC of every queued word. It assembles two-word instructions (JMP, CALL, LDS, STS) before presenting them, so the core never stalls to fetch a second word. It supports absolute redirects with a flush, sits between the program ROM and the core, and replaces PC+offset muxing inside fetch.

Parameters:
PC_W, 16, program-counter / word-address width
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
RESET_PC, 0, PC loaded on reset (PC_W bits)

Ports:
CLK  input  1  clock
RST  input  1  reset; synchronous, active-high
prog_req  output  1  fetch request this cycle
prog_addr  output  PC_W  word address of request
prog_data  input  16  ROM word; valid exactly 1 cycle after an accepted prog_req
redirect  input  1  flush queue, restart fetch at redirect_pc
redirect_pc  input  PC_W  absolute target; core computes relative targets
instr_valid  output  1  instr/instr_ext/instr_pc hold a complete instruction
instr_ready  input  1  core consumes the instruction this cycle
instr  output  16  first word; 16'h0000 (NOP) when not valid
instr_ext  output  16  second word when instr_is32, else 0
instr_is32  output  1  two-word instruction
instr_pc  output  PC_W  address of the first word
next_pc  output  PC_W  instr_pc+1 or +2; the return address for CALL/RCALL

Behaviour:
- Reset: fetch_pc=RESET_PC; queue empty; in-flight=0; prog_req=0; instr_valid=0; instr=0; instr_ext=0; instr_is32=0; instr_pc=RESET_PC. The first prog_req goes out the cycle after RST deasserts.
- Queue entry = {word[15:0], pc[PC_W-1:0]}. Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH, with MSB comparison for full/empty.
- Issue: prog_req=1 when count + inflight < DEPTH and no redirect this cycle. prog_addr=fetch_pc, then fetch_pc += 1, which wraps modulo 2^PC_W.
- Return: the word arriving on prog_data the cycle after an issue is written to the tail with its issue PC. The queue never overflows, because issue is gated by reserved slots.
- Two-word detect on the head word, masked match:
  - JMP 1001010xxxxx110x
  - CALL 1001010xxxxx111x
  - LDS 1001000xxxxx0000
  - STS 1001001xxxxx0000
- instr_valid=1 when count>=1 for a one-word instruction, or count>=2 for a two-word instruction. Outputs are combinational from the head and head+1 entries.
- Consume: when instr_valid & instr_ready, the head advances by 1 or 2. Enqueue and dequeue in the same cycle are legal, and count updates net.
- instr_ready while !instr_valid is ignored.
- Redirect, effective on the next edge:
  - queue cleared
  - fetch_pc=redirect_pc
  - an in-flight word returning the following cycle is discarded, via a 1-bit epoch tag on each in-flight request
  - prog_req=0 during the redirect cycle
  - first target request the cycle after redirect
  - redirect-to-instr_valid latency = 2 cycles (issue, return)
- Redirect together with instr_ready: the consume is honoured (the core has executed it), then the flush applies. Redirect wins over an enqueue in the same cycle.
- RST mid-operation overrides redirect and all traffic.
- Full queue: prog_req=0 until a consume frees space. Empty queue: instr_valid=0 and instr=NOP.
- Two-word instruction at the tail with count=DEPTH-1: it waits for the next return; no deadlock, since DEPTH>=2.

Optional Feature:
AVR_PREFETCH_STATS_EN:
- Defined: adds outputs flush_count[15:0] (redirects taken) and starve_count[15:0] (cycles with instr_ready=1 & instr_valid=0). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- avr_pkg:
  - NOP constant
  - two-word opcode mask/match constants
  - function is_two_word(word)
  - pc_src encoding constants, retained for core compatibility
- One sub-module: avr_prefetch_fifo (parametrised DEPTH, width 16+PC_W, dual-read head/head+1, flush input). The unit instantiates it and owns the issue, epoch and assembly logic.

Test Plan:
- Reset, then ROM[0..3]={E0F5,0000,0000,0000} with instr_ready=1: prog_addr 0,1,2… on consecutive cycles; instr=E0F5, instr_pc=0 valid 2 cycles after RST falls.
- ROM[0..1]={940C,0010} (JMP 0x10): instr_is32=1, instr=940C, instr_ext=0010, next_pc=2, consumes 2 entries.
- instr_ready=0 held for 10 cycles, DEPTH=4: prog_req drops after 4 issues; count=4; no words lost; resumes in order with PCs 0..3.
- redirect=1 with redirect_pc=0x20 while 3 queued and 1 in flight: next instr_pc=0x20 exactly 2 cycles later; no stale word from addresses 4+ appears.
- redirect coincident with instr_ready on PC 5: PC 5 consumed once; next delivered instr_pc=redirect_pc.
- With AVR_PREFETCH_STATS_EN, 3 redirects plus 5 starved cycles: flush_count=3, starve_count=5. Without the macro, compile has no stats ports.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared AVR fetch definitions: NOP word, two-word opcode masks and the
// pc_src encoding that the core still decodes.
package avr_pkg;

  localparam logic [15:0] NOP = 16'h0000;

  // Two-word opcodes: the second word is an address or a data-space operand.
  localparam logic [15:0] JMP_MASK   = 16'hFE0E;
  localparam logic [15:0] JMP_MATCH  = 16'h940C;
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;
  localparam logic [15:0] LDS_MASK   = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH  = 16'h9000;
  localparam logic [15:0] STS_MASK   = 16'hFE0F;
  localparam logic [15:0] STS_MATCH  = 16'h9200;

  typedef enum logic [1:0] {
    PC_SRC_INC = 2'd0,
    PC_SRC_REL = 2'd1,
    PC_SRC_ABS = 2'd2,
    PC_SRC_IND = 2'd3
  } pc_src_e;

  function automatic logic is_two_word(input logic [15:0] word);
    return ((word & JMP_MASK) == JMP_MATCH) ||
           ((word & CALL_MASK) == CALL_MATCH) ||
           ((word & LDS_MASK) == LDS_MATCH) ||
           ((word & STS_MASK) == STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// Prefetch queue: DEPTH entries of W bits, head and head+1 readable together,
// pops of 0/1/2 per cycle, and a flush that empties it on the next edge.
module avr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  parameter int HI_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic [1:0]               pop_n_i,
  output logic [W-1:0]             head_o,
  output logic [HI_W-1:0]          head1_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [AW-1:0] rd_idx, rd1_idx;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    rd_idx  = rd_q[AW-1:0];
    rd1_idx = rd_idx + AW'(1);
    head_o  = mem_q[rd_idx];
    head1_o = mem_q[rd1_idx][W-1 -: HI_W];
    empty_o = (wr_q == rd_q);
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    count_o = wr_q - rd_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      wr_d = wr_q + PW'(push_i);
      rd_d = rd_q + PW'(pop_n_i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/avr_prefetch_unit.sv
// AVR prefetch unit: queues ROM words with their PCs, assembles two-word
// instructions and handles absolute redirects. Optional AVR_PREFETCH_STATS_EN
// adds saturating flush/starve counters.
module avr_prefetch_unit
  import avr_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            prog_req,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [15:0]     instr,
  output logic [15:0]     instr_ext,
  output logic            instr_is32,
  output logic [PC_W-1:0] instr_pc,
  output logic [PC_W-1:0] next_pc
`ifdef AVR_PREFETCH_STATS_EN
  ,
  output logic [15:0]     flush_count,
  output logic [15:0]     starve_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 16 + PC_W;
  localparam int RW = AW + 2;

  logic [EW-1:0]   head;
  logic [15:0]     head1_word;
  logic [AW:0]     count;
  logic            fifo_full, fifo_empty;
  logic            push;
  logic [1:0]      pop_n;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] stream_pc_q, stream_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q, epoch_d;

  logic [15:0]     head_word;
  logic [PC_W-1:0] head_pc;
  logic            head_is32, have_two, consume;
  logic [RW-1:0]   reserved;

  avr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .HI_W  (16)
  ) u_fifo (
    .CLK         (CLK),
    .RST         (RST),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i ({prog_data, fetch_pc_q - PC_W'(1)}),
    .pop_n_i     (pop_n),
    .head_o      (head),
    .head1_o     (head1_word),
    .count_o     (count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    head_word   = head[EW-1 -: 16];
    head_pc     = head[PC_W-1:0];
    head_is32   = is_two_word(head_word);
    have_two    = (count >= (AW+1)'(2));
    instr_valid = !fifo_empty && (!head_is32 || have_two);
    instr       = instr_valid ? head_word : NOP;
    instr_is32  = instr_valid && head_is32;
    instr_ext   = instr_is32 ? head1_word : 16'h0000;
    // With nothing queued, report where the stream will resume.
    instr_pc    = fifo_empty ? stream_pc_q : head_pc;
    next_pc     = instr_pc + (instr_is32 ? PC_W'(2) : PC_W'(1));
    consume     = instr_valid && instr_ready;
    pop_n       = consume ? (instr_is32 ? 2'd2 : 2'd1) : 2'd0;

    // Issue only into slots not already claimed by queued or returning words.
    reserved    = RW'(count) + RW'(inflight_q);
    prog_req    = !RST && !redirect && !fifo_full && (reserved < RW'(DEPTH));
    prog_addr   = fetch_pc_q;
    push        = inflight_q && (inflight_epoch_q == epoch_q) && !redirect;

    fetch_pc_d       = fetch_pc_q;
    stream_pc_d      = stream_pc_q;
    inflight_d       = prog_req;
    inflight_epoch_d = epoch_q;
    epoch_d          = epoch_q;
    if (redirect) begin
      fetch_pc_d  = redirect_pc;
      stream_pc_d = redirect_pc;
      epoch_d     = !epoch_q;
    end else begin
      if (prog_req) fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (consume) stream_pc_d = next_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q       <= RESET_PC;
      stream_pc_q      <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      stream_pc_q      <= stream_pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

`ifdef AVR_PREFETCH_STATS_EN
  logic [15:0] flush_count_q, flush_count_d;
  logic [15:0] starve_count_q, starve_count_d;

  always_comb begin
    flush_count_d  = flush_count_q;
    starve_count_d = starve_count_q;
    if (redirect && (flush_count_q != 16'hFFFF))
      flush_count_d = flush_count_q + 16'd1;
    if (instr_ready && !instr_valid && (starve_count_q != 16'hFFFF))
      starve_count_d = starve_count_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_count_q  <= 16'd0;
      starve_count_q <= 16'd0;
    end else begin
      flush_count_q  <= flush_count_d;
      starve_count_q <= starve_count_d;
    end
  end

  assign flush_count  = flush_count_q;
  assign starve_count = starve_count_q;
`endif

endmodule
